pipe_out_block_arbiter: RTL

- Shares one block-throttled PipeOut endpoint between NUM_SRC first-word-fall-through (FWFT) source FIFOs.
- Grants the pipe to one source for exactly one block of BLOCK_WORDS words. Asserts pipe_out_ready only while the granted source can supply the whole block.
- Rotates grants round-robin between sources.
- Sits in the okClk domain between the PipeOut endpoint and the per-channel capture FIFOs.

---
 rtl/pipe_out_block_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pipe_out_block_arbiter.sv
// Round-robin block arbiter sharing one PipeOut endpoint between FWFT sources.
// Optional block header word enabled by PIPE_ARB_HEADER_EN.
module pipe_out_block_arbiter #(
  parameter int NUM_SRC     = 2,
  parameter int BLOCK_WORDS = 256,
  parameter int LEVEL_W     = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         src_enable,
  input  logic [NUM_SRC*LEVEL_W-1:0] src_count,
  input  logic [NUM_SRC*32-1:0]      src_data,
  output logic [NUM_SRC-1:0]         src_rd,
  input  logic                       pipe_out_read,
  output logic                       pipe_out_ready,
  output logic [31:0]                pipe_out_data,
  output logic [2:0]                 grant_id,
  output logic                       busy,
  output logic                       underflow
);

  localparam int CW = $clog2(BLOCK_WORDS);
`ifdef PIPE_ARB_HEADER_EN
  localparam int NEED = BLOCK_WORDS - 1;
`else
  localparam int NEED = BLOCK_WORDS;
`endif
  localparam logic [LEVEL_W:0] NEED_L = (LEVEL_W+1)'(NEED);
  localparam logic [CW-1:0] LAST_W = CW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    grant_q, ptr_q, ptr_nx, pick;
  logic [CW-1:0] word_cnt;
  logic [31:0]   data_q, head;
  logic          under_q, found, last, hdr_word, rd_ok;
  logic [NUM_SRC-1:0]   elig;
  logic [2*NUM_SRC-1:0] rot;
  logic [3:0]    sum;
`ifdef PIPE_ARB_HEADER_EN
  logic [15:0]   seq_q;
`endif

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_SRC; i++)
      elig[i] = src_enable[i] &&
                ({1'b0, src_count[i*LEVEL_W +: LEVEL_W]} >= NEED_L);
  end

  // Doubled mask shifted by the pointer gives the wrap-around scan order.
  always_comb begin
    rot   = {elig, elig} >> ptr_q;
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_q} + 4'(k);
        if (sum >= 4'(NUM_SRC))
          sum = sum - 4'(NUM_SRC);
        pick  = sum[2:0];
      end
    end
  end

  always_comb begin
    head = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (grant_q == 3'(i))
        head = src_data[i*32 +: 32];
  end

`ifdef PIPE_ARB_HEADER_EN
  assign hdr_word = (word_cnt == '0);
`else
  assign hdr_word = 1'b0;
`endif

  assign last   = (word_cnt == LAST_W);
  assign rd_ok  = !reset && state_q == GRANT && pipe_out_read;
  assign ptr_nx = (grant_q == 3'(NUM_SRC - 1)) ? 3'd0 : grant_q + 3'd1;

  always_comb begin
    src_rd = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (rd_ok && !hdr_word && grant_q == 3'(i))
        src_rd[i] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = GRANT;
      GRANT:   if (pipe_out_read && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      word_cnt <= '0;
      data_q   <= '0;
      under_q  <= 1'b0;
`ifdef PIPE_ARB_HEADER_EN
      seq_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found)
        grant_q <= pick;
      if (state_q == GRANT && pipe_out_read) begin
`ifdef PIPE_ARB_HEADER_EN
        data_q <= hdr_word ?
                  {8'hA5, 5'b0, grant_q, seq_q} : head;
        if (last)
          seq_q <= seq_q + 16'd1;
`else
        data_q <= head;
`endif
        word_cnt <= last ? '0 : word_cnt + 1'b1;
        if (last)
          ptr_q <= ptr_nx;
      end
      if (pipe_out_read && state_q != GRANT) begin
        under_q <= 1'b1;
        data_q  <= '0;
      end
    end
  end

  assign pipe_out_ready = (state_q == GRANT);
  assign busy           = (state_q == GRANT);
  assign pipe_out_data  = data_q;
  assign grant_id       = grant_q;
  assign underflow      = under_q;

endmodule
